vx_writeback_arbiter: RTL and testbench
=======================================

# vx_writeback_arbiter

Write side of the per-warp register file: merges execute-stage (ALU) results and out-of-order memory load responses into the single register write port consumed by the context/register-file block. ALU results are forwarded through a register; load responses are buffered in a small FIFO and arbitrated against the ALU stream with a starvation guard. Outputs drive the register file's write-warp, write-enable, destination, per-thread valid and data inputs directly.

## Interface
- NT, default `NT (4): threads per warp; data buses are NT*32 wide, thread lane i at bits [32i+31:32i]
- FIFO_DEPTH, default 4: load-response buffer entries, power of two ≥ 2
- AGE_MAX, default 8: cycles a FIFO head may wait before forced drain
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_alu_valid  in  1  ALU result present
- in_alu_warp  in  1  warp id of result
- in_alu_wb  in  1  instruction writes a register
- in_alu_rd  in  5  destination register
- in_alu_mask  in  NT  active threads
- in_alu_data  in  NT*32  result data
- out_alu_ready  out  1  ALU result accepted this cycle
- in_mem_valid  in  1  load response present
- in_mem_warp  in  1  warp id
- in_mem_rd  in  5  destination register
- in_mem_mask  in  NT  active threads
- in_mem_data  in  NT*32  load data
- out_mem_ready  out  1  FIFO can accept
- out_wb_warp  out  1  write warp
- out_write_register  out  1  write enable
- out_rd  out  5  write destination
- out_valid  out  NT  per-thread write enable
- out_write_data  out  NT*32  write data
- out_fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- Transfer on a port = valid && ready in the same cycle.
- out_mem_ready = (count < FIFO_DEPTH); no push when full, independent of same-cycle pop.
- Select each cycle (combinational): pop_fifo = (count != 0) && (!in_alu_valid || count == FIFO_DEPTH || age >= AGE_MAX); out_alu_ready = !pop_fifo.
- Selected record (FIFO head or ALU input) is registered into the outputs; with neither, outputs register a bubble (write enable 0, out_valid 0).
- out_write_register = 1 only if rd != 0, mask != 0, and (for ALU) in_alu_wb = 1; otherwise the record is consumed but written as a bubble. out_valid = mask when enabled, else 0.
- Age counter: resets to 0 on any pop or when FIFO empty; otherwise increments (saturating at AGE_MAX) each cycle the head is not popped.
- Simultaneous push and pop: count unchanged; pointers wrap modulo FIFO_DEPTH.
- FIFO order is strict arrival order; no reordering between loads.

## Timing
- ALU: accepted in cycle t -> outputs valid in cycle t+1 (1-cycle latency).
- Memory: pushed at edge ending cycle t -> head eligible in t+1 -> earliest output t+2.
- Outputs change only on clk rising edge or reset assertion.
- Reset (async, any time): out_write_register 0, out_valid 0, out_rd 0, out_wb_warp 0, out_write_data 0, count 0, pointers 0, age 0; in-flight FIFO contents discarded. out_mem_ready reads 1 and out_alu_ready 1 while reset_n low.
- Release: first transfers accepted in the first full cycle with reset_n high.

## Structure
- Shared define/package: NT, FIFO_DEPTH, AGE_MAX, writeback record layout (warp, rd, mask, data).
- Sub-module: VX_wb_fifo — generic synchronous FIFO (push/pop/full/empty/count, async active-low reset) holding the memory record; arbiter and output register stay in this block.

## Test plan
- ALU only: in_alu_valid=1, rd=5, mask=4'b1111, data lanes 0x11..0x44 -> next cycle write_register=1, out_rd=5, out_valid=4'b1111, same data; out_alu_ready held 1.
- rd=0 or in_alu_wb=0: accepted, next cycle write_register=0, out_valid=0; no FIFO change.
- Load with idle ALU: push rd=7 mask=4'b0101 at t -> output at t+2, write_register=1, out_valid=4'b0101.
- Fill and starvation: continuous ALU traffic, push 4 loads -> out_mem_ready=0 at count 4; FIFO pops with out_alu_ready=0 until count<4; with 1 load and constant ALU, load drains exactly after AGE_MAX=8 waiting cycles.
- Push+pop same cycle at count 2 -> count stays 2, order preserved across pointer wrap (8+ loads sequence in order).
- Assert reset_n low with count 3 and a valid output -> outputs and out_fifo_count 0 immediately (before next edge); after release, no stale loads emerge.

Source files
------------

// File: rtl/vx_writeback_arbiter_pkg.sv
// Shared parameters and helpers for the register-file write side:
// default sizing, writeback source selection and the write-enable rule.
package vx_writeback_arbiter_pkg;

  localparam int NT_DEF         = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int AGE_MAX_DEF    = 8;
  localparam int RD_W           = 5;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_MEM
  } wb_sel_e;

  // A consumed record only writes when it targets a real register with live threads.
  function automatic logic wb_enable(input logic [RD_W-1:0] rd,
                                     input logic            mask_any,
                                     input logic            wb);
    return wb && (rd != '0) && mask_any;
  endfunction

endpackage

// File: rtl/VX_wb_fifo.sv
// Generic synchronous FIFO with occupancy count; pushes are refused when full
// and pops when empty, so callers may drive push/pop unconditionally.
module VX_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/vx_writeback_arbiter.sv
// Merges ALU results and buffered load responses onto the single register-file
// write port, with a FIFO-full / head-age starvation guard favouring loads.
module vx_writeback_arbiter
  import vx_writeback_arbiter_pkg::*;
#(
  parameter int NT         = NT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int AGE_MAX    = AGE_MAX_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_alu_valid,
  input  logic                         in_alu_warp,
  input  logic                         in_alu_wb,
  input  logic [RD_W-1:0]              in_alu_rd,
  input  logic [NT-1:0]                in_alu_mask,
  input  logic [NT*32-1:0]             in_alu_data,
  output logic                         out_alu_ready,
  input  logic                         in_mem_valid,
  input  logic                         in_mem_warp,
  input  logic [RD_W-1:0]              in_mem_rd,
  input  logic [NT-1:0]                in_mem_mask,
  input  logic [NT*32-1:0]             in_mem_data,
  output logic                         out_mem_ready,
  output logic                         out_wb_warp,
  output logic                         out_write_register,
  output logic [RD_W-1:0]              out_rd,
  output logic [NT-1:0]                out_valid,
  output logic [NT*32-1:0]             out_write_data,
  output logic [$clog2(FIFO_DEPTH):0]  out_fifo_count
);

  localparam int REC_W = 1 + RD_W + NT + NT*32;
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  logic [REC_W-1:0] head_rec;
  logic             head_warp;
  logic [RD_W-1:0]  head_rd;
  logic [NT-1:0]    head_mask;
  logic [NT*32-1:0] head_data;
  logic             fifo_full, fifo_empty, pop_fifo;
  wb_sel_e          sel;

  logic             wb_warp_q, wb_warp_d;
  logic             write_reg_q, write_reg_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [NT-1:0]    valid_q, valid_d;
  logic [NT*32-1:0] data_q, data_d;
  logic [AGE_W-1:0] age_q, age_d;

  VX_wb_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_mem_valid),
    .push_data ({in_mem_warp, in_mem_rd, in_mem_mask, in_mem_data}),
    .pop       (pop_fifo),
    .head_data (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (out_fifo_count)
  );

  assign {head_warp, head_rd, head_mask, head_data} = head_rec;

  // Loads win when the ALU is idle, the buffer is full, or the head has waited too long.
  assign pop_fifo      = !fifo_empty &&
                         (!in_alu_valid || fifo_full || age_q >= AGE_W'(AGE_MAX));
  assign out_alu_ready = !pop_fifo;
  assign out_mem_ready = !fifo_full;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    sel         = SEL_NONE;
    wb_warp_d   = 1'b0;
    write_reg_d = 1'b0;
    rd_d        = '0;
    valid_d     = '0;
    data_d      = '0;
    age_d       = '0;

    if (pop_fifo)          sel = SEL_MEM;
    else if (in_alu_valid) sel = SEL_ALU;

    unique case (sel)
      SEL_MEM: begin
        wb_warp_d   = head_warp;
        write_reg_d = wb_enable(head_rd, |head_mask, 1'b1);
        rd_d        = head_rd;
        valid_d     = write_reg_d ? head_mask : '0;
        data_d      = head_data;
      end
      SEL_ALU: begin
        wb_warp_d   = in_alu_warp;
        write_reg_d = wb_enable(in_alu_rd, |in_alu_mask, in_alu_wb);
        rd_d        = in_alu_rd;
        valid_d     = write_reg_d ? in_alu_mask : '0;
        data_d      = in_alu_data;
      end
      default: ;
    endcase

    if (!pop_fifo && !fifo_empty)
      age_d = (age_q < AGE_W'(AGE_MAX)) ? age_q + AGE_W'(1) : age_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_warp_q   <= 1'b0;
      write_reg_q <= 1'b0;
      rd_q        <= '0;
      valid_q     <= '0;
      data_q      <= '0;
      age_q       <= '0;
    end else begin
      wb_warp_q   <= wb_warp_d;
      write_reg_q <= write_reg_d;
      rd_q        <= rd_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      age_q       <= age_d;
    end
  end

  assign out_wb_warp        = wb_warp_q;
  assign out_write_register = write_reg_q;
  assign out_rd             = rd_q;
  assign out_valid          = valid_q;
  assign out_write_data     = data_q;

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Scoreboard bench: a queue-based model predicts each cycle's write-port record
// and handshake outputs; a separate monitor compares registered outputs.
module tb_vx_writeback_arbiter;

  localparam int NT      = 4;
  localparam int DEPTH   = 4;
  localparam int AGE_MAX = 8;
  localparam int DW      = NT * 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_alu_valid, in_alu_warp, in_alu_wb;
  logic [4:0]    in_alu_rd;
  logic [NT-1:0] in_alu_mask;
  logic [DW-1:0] in_alu_data;
  logic          out_alu_ready;
  logic          in_mem_valid, in_mem_warp;
  logic [4:0]    in_mem_rd;
  logic [NT-1:0] in_mem_mask;
  logic [DW-1:0] in_mem_data;
  logic          out_mem_ready, out_wb_warp, out_write_register;
  logic [4:0]    out_rd;
  logic [NT-1:0] out_valid;
  logic [DW-1:0] out_write_data;
  logic [2:0]    out_fifo_count;

  always #5 clk = ~clk;

  vx_writeback_arbiter #(.NT(NT), .FIFO_DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_alu_valid(in_alu_valid), .in_alu_warp(in_alu_warp), .in_alu_wb(in_alu_wb),
    .in_alu_rd(in_alu_rd), .in_alu_mask(in_alu_mask), .in_alu_data(in_alu_data),
    .out_alu_ready(out_alu_ready),
    .in_mem_valid(in_mem_valid), .in_mem_warp(in_mem_warp), .in_mem_rd(in_mem_rd),
    .in_mem_mask(in_mem_mask), .in_mem_data(in_mem_data), .out_mem_ready(out_mem_ready),
    .out_wb_warp(out_wb_warp), .out_write_register(out_write_register), .out_rd(out_rd),
    .out_valid(out_valid), .out_write_data(out_write_data), .out_fifo_count(out_fifo_count)
  );

  typedef struct {
    logic          alu_v, alu_wb, alu_warp;
    logic [4:0]    alu_rd;
    logic [NT-1:0] alu_mask;
    logic [DW-1:0] alu_data;
    logic          mem_v, mem_warp;
    logic [4:0]    mem_rd;
    logic [NT-1:0] mem_mask;
    logic [DW-1:0] mem_data;
  } stim_t;

  typedef struct {
    logic          warp;
    logic [4:0]    rd;
    logic [NT-1:0] mask;
    logic [DW-1:0] data;
  } load_t;

  typedef struct {
    logic          en, warp;
    logic [4:0]    rd;
    logic [NT-1:0] vmask;
    logic [DW-1:0] data;
  } exp_t;

  exp_t  sb[$];
  load_t pending[$];
  int    age;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic stim_t mk(input logic av, input logic awb, input logic [4:0] ard,
                               input logic [NT-1:0] amask, input logic mv,
                               input logic [4:0] mrd, input logic [NT-1:0] mmask);
    stim_t s;
    s.alu_v = av;  s.alu_wb = awb; s.alu_warp = 1'($urandom); s.alu_rd = ard;
    s.alu_mask = amask; s.alu_data = rnd_data();
    s.mem_v = mv;  s.mem_warp = 1'($urandom); s.mem_rd = mrd;
    s.mem_mask = mmask; s.mem_data = rnd_data();
    return s;
  endfunction

  task automatic apply(input stim_t s);
    in_alu_valid = s.alu_v;  in_alu_wb = s.alu_wb; in_alu_warp = s.alu_warp;
    in_alu_rd    = s.alu_rd; in_alu_mask = s.alu_mask; in_alu_data = s.alu_data;
    in_mem_valid = s.mem_v;  in_mem_warp = s.mem_warp; in_mem_rd = s.mem_rd;
    in_mem_mask  = s.mem_mask; in_mem_data = s.mem_data;
  endtask

  // One cycle: drive, check handshakes against the model, predict the registered record.
  task automatic drive(input stim_t s);
    exp_t  e;
    load_t l;
    int    sz;
    bit    pop;
    @(negedge clk);
    apply(s);
    #1;
    sz  = pending.size();
    pop = (sz != 0) && (!s.alu_v || sz == DEPTH || age >= AGE_MAX);
    check("alu_ready", out_alu_ready, !pop);
    check("mem_ready", out_mem_ready, sz < DEPTH);
    check("fifo_count", out_fifo_count, sz);
    e = '{default: '0};
    if (pop) begin
      l = pending[0];
      e.en = (l.rd != 0) && (l.mask != 0);
      e.warp = l.warp; e.rd = l.rd; e.data = l.data;
      e.vmask = e.en ? l.mask : '0;
    end else if (s.alu_v) begin
      e.en = s.alu_wb && (s.alu_rd != 0) && (s.alu_mask != 0);
      e.warp = s.alu_warp; e.rd = s.alu_rd; e.data = s.alu_data;
      e.vmask = e.en ? s.alu_mask : '0;
    end
    sb.push_back(e);
    if (pop) pending.delete(0);
    if (s.mem_v && sz < DEPTH)
      pending.push_back('{s.mem_warp, s.mem_rd, s.mem_mask, s.mem_data});
    if (pop || sz == 0) age = 0;
    else if (age < AGE_MAX) age = age + 1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(mk(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"},    out_write_register, 1'b0);
    check({tag, "_valid"}, out_valid, '0);
    check({tag, "_rd"},    out_rd, '0);
    check({tag, "_warp"},  out_wb_warp, 1'b0);
    check({tag, "_data"},  out_write_data, '0);
    check({tag, "_count"}, out_fifo_count, '0);
    check({tag, "_alu_rdy"}, out_alu_ready, 1'b1);
    check({tag, "_mem_rdy"}, out_mem_ready, 1'b1);
  endtask

  // Monitor: every registered output after a predicted cycle is compared in order.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("wr_en", out_write_register, e.en);
          check("out_valid", out_valid, e.vmask);
          if (e.en) begin
            check("out_rd", out_rd, e.rd);
            check("out_warp", out_wb_warp, e.warp);
            check("out_data", out_write_data, e.data);
          end
        end else if (out_write_register) begin
          check("unexpected_write", out_write_register, 1'b0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    stim_t s;
    age = 0;
    apply(mk(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0));
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // ALU only, fixed lane pattern, plus non-writing records.
    for (int i = 0; i < 3; i++) begin
      s = mk(1'b1, 1'b1, 5'd5, 4'b1111, 1'b0, 5'd0, '0);
      s.alu_data = {32'h44, 32'h33, 32'h22, 32'h11};
      drive(s);
    end
    drive(mk(1'b1, 1'b1, 5'd0, 4'b1111, 1'b0, 5'd0, '0));
    drive(mk(1'b1, 1'b0, 5'd9, 4'b1111, 1'b0, 5'd0, '0));
    drive(mk(1'b1, 1'b1, 5'd9, 4'b0000, 1'b0, 5'd0, '0));

    // Single load with an idle ALU.
    drive(mk(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 4'b0101));
    idle_cycles(3);

    // Fill under continuous ALU traffic, then drain with ALU still present.
    for (int i = 0; i < 6; i++) drive(mk(1'b1, 1'b1, 5'(i + 1), 4'b1111, 1'b1, 5'(i + 10), 4'b0011));
    for (int i = 0; i < 6; i++) drive(mk(1'b1, 1'b1, 5'd3, 4'b1010, 1'b0, 5'd0, '0));
    idle_cycles(6);

    // Starvation guard: one load waits behind constant ALU traffic.
    drive(mk(1'b1, 1'b1, 5'd4, 4'b1111, 1'b1, 5'd12, 4'b1111));
    for (int i = 0; i < 12; i++) drive(mk(1'b1, 1'b1, 5'd4, 4'b1111, 1'b0, 5'd0, '0));
    idle_cycles(2);

    // Push and pop together at count 2, long enough to wrap the pointers.
    for (int i = 0; i < 2; i++) drive(mk(1'b1, 1'b1, 5'd6, 4'b0001, 1'b1, 5'(i + 20), 4'b1100));
    for (int i = 0; i < 10; i++) drive(mk(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'(i + 1), 4'($urandom_range(1, 15))));
    idle_cycles(4);

    // Asynchronous reset with three loads buffered and an ALU write on the outputs.
    for (int i = 0; i < 3; i++) drive(mk(1'b1, 1'b1, 5'd8, 4'b1111, 1'b1, 5'(i + 25), 4'b1111));
    drive(mk(1'b1, 1'b1, 5'd8, 4'b1111, 1'b0, 5'd0, '0));
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    apply(mk(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0));
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    pending.delete();
    age = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(8);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive(mk(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 9),
               5'($urandom), 4'($urandom), 1'($urandom_range(0, 9) < 4),
               5'($urandom), 4'($urandom)));
    end
    idle_cycles(8);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
